// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the round-robin memory arbiter.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } state_t;

   localparam int unsigned DEF_NUM_CORES  = 2;
   localparam int unsigned DEF_ADDR_W     = 32;
   localparam int unsigned DEF_DATA_W     = 32;
   localparam int unsigned DEF_RD_LATENCY = 1;

   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin winner search from a rotating priority pointer; the pointer
// advances past the winner whenever the owner accepts the grant.
module rr_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned NUM_CORES = DEF_NUM_CORES,
   localparam int unsigned IW = idx_width(NUM_CORES)
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [NUM_CORES-1:0] req,
   input  logic                 accept,
   output logic [NUM_CORES-1:0] onehot,
   output logic [IW-1:0]        index,
   output logic                 found,
   output logic [IW-1:0]        ptr
);

   int unsigned j;

   always_comb begin
      onehot = '0;
      index  = '0;
      found  = 1'b0;
      j      = 0;
      for (int unsigned i = 0; i < NUM_CORES; i++) begin
         j = 32'(ptr) + i;
         if (j >= NUM_CORES) j = j - NUM_CORES;
         if (!found && req[IW'(j)]) begin
            found           = 1'b1;
            index           = IW'(j);
            onehot[IW'(j)]  = 1'b1;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         ptr <= '0;
      end else if (accept && found) begin
         ptr <= (index == IW'(NUM_CORES - 1)) ? '0 : index + 1'b1;
      end
   end

endmodule

// File: rtl/mem_arbiter_rr.sv
// Round-robin arbiter of NUM_CORES core ports onto one shared memory, one
// transaction in flight. Optional perf counters via MEM_ARB_PERF_CNT_EN.
module mem_arbiter_rr
   import mem_arb_pkg::*;
#(
   parameter int unsigned NUM_CORES  = DEF_NUM_CORES,
   parameter int unsigned ADDR_W     = DEF_ADDR_W,
   parameter int unsigned DATA_W     = DEF_DATA_W,
   parameter int unsigned RD_LATENCY = DEF_RD_LATENCY
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic [NUM_CORES-1:0]        core_req,
   input  logic [NUM_CORES-1:0]        core_write,
   input  logic [NUM_CORES*ADDR_W-1:0] core_addr,
   input  logic [NUM_CORES*DATA_W-1:0] core_wdata,
   output logic [NUM_CORES-1:0]        core_gnt,
   output logic [NUM_CORES-1:0]        core_rvalid,
   output logic [NUM_CORES*DATA_W-1:0] core_rdata,
   output logic                        mem_en,
   output logic                        mem_write,
   output logic [ADDR_W-1:0]           mem_addr,
   output logic [DATA_W-1:0]           mem_wdata,
   input  logic [DATA_W-1:0]           mem_rdata
`ifdef MEM_ARB_PERF_CNT_EN
   ,
   output logic [NUM_CORES*32-1:0]     perf_gnt_cnt,
   output logic [NUM_CORES*32-1:0]     perf_stall_cnt
`endif
);

   localparam int unsigned IW = idx_width(NUM_CORES);
   localparam int unsigned CW = idx_width(RD_LATENCY);

   state_t                 state;
   logic [IW-1:0]          cur;
   logic [CW-1:0]          cnt;
   logic [NUM_CORES-1:0]   win;
   logic [IW-1:0]          win_idx;
   logic                   found;
   logic [IW-1:0]          ptr;

   rr_arbiter #(.NUM_CORES(NUM_CORES)) u_arb (
      .clock  (clock),
      .reset  (reset),
      .req    (core_req),
      .accept (state == IDLE),
      .onehot (win),
      .index  (win_idx),
      .found  (found),
      .ptr    (ptr)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= IDLE;
         core_gnt    <= '0;
         core_rvalid <= '0;
         core_rdata  <= '0;
         mem_en      <= 1'b0;
         mem_write   <= 1'b0;
         mem_addr    <= '0;
         mem_wdata   <= '0;
         cur         <= '0;
         cnt         <= '0;
      end else begin
         core_gnt    <= '0;
         core_rvalid <= '0;
         mem_en      <= 1'b0;
         case (state)
            IDLE: begin
               if (found) begin
                  core_gnt  <= win;
                  mem_en    <= 1'b1;
                  mem_write <= core_write[win_idx];
                  mem_addr  <= core_addr[win_idx*ADDR_W +: ADDR_W];
                  mem_wdata <= core_wdata[win_idx*DATA_W +: DATA_W];
                  cur       <= win_idx;
                  state     <= ISSUE;
               end
            end
            // mem_write still holds the issued operation here
            ISSUE: begin
               if (mem_write) begin
                  state <= IDLE;
               end else begin
                  cnt   <= CW'(RD_LATENCY - 1);
                  state <= WAIT;
               end
            end
            WAIT: begin
               if (cnt == '0) begin
                  core_rvalid[cur]                  <= 1'b1;
                  core_rdata[cur*DATA_W +: DATA_W]  <= mem_rdata;
                  state                             <= IDLE;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef MEM_ARB_PERF_CNT_EN
   // grant count wraps; stall count saturates
   always_ff @(posedge clock) begin
      if (reset) begin
         perf_gnt_cnt   <= '0;
         perf_stall_cnt <= '0;
      end else begin
         for (int unsigned i = 0; i < NUM_CORES; i++) begin
            if (core_gnt[i])
               perf_gnt_cnt[i*32 +: 32] <= perf_gnt_cnt[i*32 +: 32] + 32'd1;
            if (core_req[i] && !core_gnt[i] && (perf_stall_cnt[i*32 +: 32] != '1))
               perf_stall_cnt[i*32 +: 32] <= perf_stall_cnt[i*32 +: 32] + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Scoreboard bench for mem_arbiter_rr (NUM_CORES=4, RD_LATENCY=3) with a
// latency-accurate memory model; perf counters checked under MEM_ARB_PERF_CNT_EN.
`timescale 1ns/1ps
module tb_mem_arbiter_rr;

   localparam int unsigned N  = 4;
   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;
   localparam int unsigned L  = 3;

   logic            clock = 1'b0;
   logic            reset = 1'b1;
   logic [N-1:0]    core_req   = '0;
   logic [N-1:0]    core_write = '0;
   logic [N*AW-1:0] core_addr  = '0;
   logic [N*DW-1:0] core_wdata = '0;
   logic [N-1:0]    core_gnt, core_rvalid;
   logic [N*DW-1:0] core_rdata;
   logic            mem_en, mem_write;
   logic [AW-1:0]   mem_addr;
   logic [DW-1:0]   mem_wdata, mem_rdata;
`ifdef MEM_ARB_PERF_CNT_EN
   logic [N*32-1:0] perf_gnt_cnt, perf_stall_cnt;
   logic [31:0]     snap_stall, snap_gnt;
`endif

   mem_arbiter_rr #(.NUM_CORES(N), .ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(L)) dut (
      .clock       (clock),
      .reset       (reset),
      .core_req    (core_req),
      .core_write  (core_write),
      .core_addr   (core_addr),
      .core_wdata  (core_wdata),
      .core_gnt    (core_gnt),
      .core_rvalid (core_rvalid),
      .core_rdata  (core_rdata),
      .mem_en      (mem_en),
      .mem_write   (mem_write),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_rdata   (mem_rdata)
`ifdef MEM_ARB_PERF_CNT_EN
      ,
      .perf_gnt_cnt   (perf_gnt_cnt),
      .perf_stall_cnt (perf_stall_cnt)
`endif
   );

   always #5 clock = ~clock;

   int unsigned cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   // memory: data for a read issued in cycle c is presented during cycle c+L
   logic [DW-1:0] ram  [256];
   logic [DW-1:0] pipe [L];
   always @(posedge clock) begin
      if (mem_en && mem_write) ram[mem_addr[7:0]] <= mem_wdata;
      pipe[0] <= (mem_en && !mem_write) ? ram[mem_addr[7:0]] : 32'hBAD0_BAD0;
      for (int i = 1; i < int'(L); i++) pipe[i] <= pipe[i-1];
   end
   assign mem_rdata = pipe[L-1];

   typedef struct {
      int unsigned   core;
      logic          wr;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
   } gnt_t;
   typedef struct {
      int unsigned   core;
      logic [DW-1:0] data;
   } rd_t;

   gnt_t gq[$];
   rd_t  rq[$];
   int   checks = 0;
   int   fails  = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // monitor: pops expectations whenever the DUT presents a grant or a read return
   gnt_t        mg;
   rd_t         mr;
   logic [N-1:0] oh;
   int unsigned rd_gnt_cyc = 0;
   always @(negedge clock) begin
      if (!reset) begin
         if (core_gnt != '0 || mem_en) begin
            if (gq.size() == 0) begin
               chk("gnt_unexpected", 64'({mem_en, core_gnt}), 64'd0);
            end else begin
               mg = gq.pop_front();
               oh = '0;
               oh[mg.core] = 1'b1;
               chk("gnt_vec",   64'({mem_en, core_gnt}), 64'({1'b1, oh}));
               chk("mem_write", 64'(mem_write), 64'(mg.wr));
               chk("mem_addr",  64'(mem_addr),  64'(mg.addr));
               chk("mem_wdata", 64'(mem_wdata), 64'(mg.wdata));
               if (!mg.wr) rd_gnt_cyc = cyc;
            end
         end
         if (core_rvalid != '0) begin
            if (rq.size() == 0) begin
               chk("rvalid_unexpected", 64'(core_rvalid), 64'd0);
            end else begin
               mr = rq.pop_front();
               oh = '0;
               oh[mr.core] = 1'b1;
               chk("rvalid_vec", 64'(core_rvalid), 64'(oh));
               chk("rdata",      64'(core_rdata[mr.core*DW +: DW]), 64'(mr.data));
               chk("rd_latency", 64'(cyc - rd_gnt_cyc), 64'(L + 1));
            end
         end
      end
   end

   task automatic set_core(input int unsigned c, input logic wr, input logic [AW-1:0] a,
                           input logic [DW-1:0] d);
      core_write[c]          = wr;
      core_addr[c*AW +: AW]  = a;
      core_wdata[c*DW +: DW] = d;
   endtask

   task automatic exp_gnt(input int unsigned c, input logic wr, input logic [AW-1:0] a,
                          input logic [DW-1:0] d);
      gnt_t g;
      g.core = c; g.wr = wr; g.addr = a; g.wdata = d;
      gq.push_back(g);
   endtask

   task automatic exp_rd(input int unsigned c, input logic [DW-1:0] d);
      rd_t r;
      r.core = c; r.data = d;
      rq.push_back(r);
   endtask

   task automatic txn(input int unsigned c, input logic wr, input logic [AW-1:0] a,
                      input logic [DW-1:0] d);
      set_core(c, wr, a, d);
      exp_gnt(c, wr, a, d);
   endtask

   // hold requests in mask until ngr grants seen; optionally drop each core on its grant
   task automatic run(input logic [N-1:0] mask, input int unsigned ngr, input bit drop,
                      input int unsigned spacing, input string tag);
      int unsigned got = 0, waited = 0, last = 0;
      core_req = mask;
      while (got < ngr && waited < 50) begin
         @(posedge clock); #1;
         waited++;
         if (core_gnt != '0) begin
            if (got == 0) chk({tag, "_first_lat"}, 64'(waited), 64'd1);
            else if (spacing != 0) chk({tag, "_spacing"}, 64'(cyc - last), 64'(spacing));
            last = cyc;
            got++;
            if (drop) core_req = core_req & ~core_gnt;
         end
      end
      if (got < ngr) chk({tag, "_timeout"}, 64'(got), 64'(ngr));
      core_req = '0;
      repeat (8) @(posedge clock);
      #1;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_gnt"},       64'(core_gnt),    64'd0);
      chk({tag, "_rvalid"},    64'(core_rvalid), 64'd0);
      chk({tag, "_mem_en"},    64'(mem_en),      64'd0);
      chk({tag, "_mem_write"}, 64'(mem_write),   64'd0);
      chk({tag, "_mem_addr"},  64'(mem_addr),    64'd0);
      chk({tag, "_mem_wdata"}, 64'(mem_wdata),   64'd0);
      for (int c = 0; c < int'(N); c++)
         chk({tag, "_rdata"}, 64'(core_rdata[c*DW +: DW]), 64'd0);
`ifdef MEM_ARB_PERF_CNT_EN
      chk({tag, "_perf_gnt"},   64'(perf_gnt_cnt[31:0]),   64'd0);
      chk({tag, "_perf_stall"}, 64'(perf_stall_cnt[31:0]), 64'd0);
`endif
   endtask

   initial begin
      // requests asserted throughout reset must not leak to any output
      for (int c = 0; c < int'(N); c++) set_core(c, 1'b1, 32'h50 + c, 32'h1111_0000 + c);
      core_req = '1;
      repeat (3) @(posedge clock);
      #1;
      chk_zero("rst");
      core_req = '0;
      reset    = 1'b0;
      repeat (2) @(posedge clock);
      #1;

      txn(0, 1'b1, 32'h10, 32'hDEADBEEF);
      run(4'b0001, 1, 1'b0, 0, "wr0");

      txn(1, 1'b0, 32'h10, 32'h0);
      exp_rd(1, 32'hDEADBEEF);
      run(4'b0010, 1, 1'b0, 0, "rd1");

      // pointer is 2; a core3 write brings it back to 0
      txn(3, 1'b1, 32'h30, 32'h3333_3333);
      run(4'b1000, 1, 1'b0, 0, "wr3");

      for (int c = 0; c < int'(N); c++) set_core(c, 1'b1, 32'h100 + c, 32'hA000_0000 + c);
      for (int k = 0; k < 6; k++)
         exp_gnt(k % 4, 1'b1, 32'h100 + (k % 4), 32'hA000_0000 + (k % 4));
      run(4'b1111, 6, 1'b0, 2, "rot");

      // pointer is 2: lone core2 twice, second search wraps from 3
      txn(2, 1'b1, 32'h20, 32'h2222_2222);
      exp_gnt(2, 1'b1, 32'h20, 32'h2222_2222);
      run(4'b0100, 2, 1'b0, 2, "lone");

      // pointer must now be 3: core3 beats core0, core0 waits 3 cycles
      txn(3, 1'b1, 32'h44, 32'h4444_4444);
      txn(0, 1'b1, 32'h40, 32'h4040_4040);
`ifdef MEM_ARB_PERF_CNT_EN
      snap_stall = perf_stall_cnt[31:0];
      snap_gnt   = perf_gnt_cnt[31:0];
`endif
      run(4'b1001, 2, 1'b1, 2, "wrap");
`ifdef MEM_ARB_PERF_CNT_EN
      chk("perf_stall0", 64'(perf_stall_cnt[31:0] - snap_stall), 64'd3);
      chk("perf_gnt0",   64'(perf_gnt_cnt[31:0] - snap_gnt),     64'd1);
`endif

      // reset while waiting for read data: transaction must vanish
      txn(0, 1'b0, 32'h100, 32'h0);
      core_req = 4'b0001;
      @(posedge clock); #1;
      core_req = '0;
      @(posedge clock); #1;
      @(posedge clock); #1;
      reset = 1'b1;
      @(posedge clock); #1;
      chk_zero("rstw");
      @(posedge clock); #1;
      reset = 1'b0;
      repeat (8) @(posedge clock);
      #1;

      txn(1, 1'b0, 32'h10, 32'h0);
      exp_rd(1, 32'hDEADBEEF);
      run(4'b0010, 1, 1'b0, 0, "rd1b");

      txn(2, 1'b0, 32'h101, 32'h0);
      exp_rd(2, 32'hA000_0001);
      run(4'b0100, 1, 1'b0, 0, "rd2");

      chk("hold_rdata1", 64'(core_rdata[1*DW +: DW]), 64'hDEADBEEF);
      chk("hold_rdata0", 64'(core_rdata[0*DW +: DW]), 64'd0);
      chk("gnt_left",    64'(gq.size()), 64'd0);
      chk("rd_left",     64'(rq.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
